// File: rtl/pm_sleep_controller.sv
// Power-management sequencer: owns cpustall, walks the CPU through RUN/DRAIN/SLEEP/SETTLE, gates core clock.
// Latency: state follows inputs by 1 cycle; all outputs are registered decodes of the state (1 more cycle).
// Backpressure: DRAIN holds until the wishbone masters report idle; any enabled wake line aborts or ends sleep.
module pm_sleep_controller #(
    parameter int NUM_WAKE     = 20,
    parameter int CNT_WIDTH    = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_WAKE-1:0]  interrupts,
    input  logic [NUM_WAKE-1:0]  wake_mask,
    input  logic [CNT_WIDTH-1:0] settle_cycles,
    input  logic                 bus_idle,
    input  logic [3:0]           pm_clksd,
    input  logic                 pm_cpu_gate,
    input  logic                 pm_wakeup,
    input  logic                 pm_lvolt,
    output logic                 pm_cpustall,
    output logic                 clk_en,
    output logic                 sleeping,
    output logic                 lvolt_en,
    output logic [NUM_WAKE:0]    wake_cause,
    output logic [CNT_WIDTH-1:0] sleep_count
);

    typedef enum logic [1:0] {RUN, DRAIN, SLEEP, SETTLE} state_t;

    localparam logic [CNT_WIDTH-1:0] DRAIN_LOAD = CNT_WIDTH'(DRAIN_CYCLES - 1);

    state_t                 state;
    logic                   gate_q;
    logic [3:0]             clksd_q;
    logic [3:0]             div_cnt;
    logic [CNT_WIDTH-1:0]   drain_cnt;
    logic [CNT_WIDTH-1:0]   settle_cnt;
    logic [NUM_WAKE-1:0]    wake_lines;
    logic                   wake_req;
    logic                   gate_rise;

    assign wake_lines = interrupts & wake_mask;
    assign wake_req   = (|wake_lines) | pm_wakeup;
    assign gate_rise  = pm_cpu_gate & ~gate_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            gate_q      <= 1'b0;
            clksd_q     <= 4'd0;
            div_cnt     <= 4'd0;
            drain_cnt   <= '0;
            settle_cnt  <= '0;
            pm_cpustall <= 1'b0;
            clk_en      <= 1'b1;
            sleeping    <= 1'b0;
            lvolt_en    <= 1'b0;
            wake_cause  <= '0;
            sleep_count <= '0;
        end else begin
            gate_q      <= pm_cpu_gate;
            clksd_q     <= pm_clksd;

            // Outputs decode the current state register, so they trail it by one cycle.
            pm_cpustall <= (state != RUN);
            sleeping    <= (state == SLEEP);
            lvolt_en    <= pm_lvolt & sleeping;
            case (state)
                RUN:     clk_en <= (div_cnt == 4'd0);
                SLEEP:   clk_en <= 1'b0;
                default: clk_en <= 1'b1;
            endcase

            if (state == SLEEP && sleep_count != '1)
                sleep_count <= sleep_count + 1'b1;

            case (state)
                RUN: begin
                    if (gate_rise && !wake_req) begin
                        state       <= DRAIN;
                        drain_cnt   <= DRAIN_LOAD;
                        sleep_count <= '0;
                        div_cnt     <= 4'd0;
                    end else if (pm_clksd != clksd_q || div_cnt >= pm_clksd) begin
                        div_cnt <= 4'd0;
                    end else begin
                        div_cnt <= div_cnt + 4'd1;
                    end
                end
                DRAIN: begin
                    // Abort takes priority over drain expiry.
                    if (wake_req) begin
                        state      <= RUN;
                        wake_cause <= {pm_wakeup, wake_lines};
                    end else if (drain_cnt == '0 && bus_idle) begin
                        state <= SLEEP;
                    end else if (drain_cnt != '0) begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                SLEEP: begin
                    if (wake_req) begin
                        state      <= SETTLE;
                        wake_cause <= {pm_wakeup, wake_lines};
                        settle_cnt <= settle_cycles;
                    end
                end
                default: begin
                    if (settle_cnt == '0)
                        state <= RUN;
                    else
                        settle_cnt <= settle_cnt - 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pm_sleep_controller.sv
// Directed bench for pm_sleep_controller: behavioural model compared every cycle plus literal spot checks.
module tb_pm_sleep_controller;

    localparam int NW = 20;
    localparam int CW = 16;
    localparam int DC = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [NW-1:0] interrupts = '0;
    logic [NW-1:0] wake_mask = '0;
    logic [CW-1:0] settle_cycles = 16'd5;
    logic          bus_idle = 1'b1;
    logic [3:0]    pm_clksd = 4'd0;
    logic          pm_cpu_gate = 1'b0;
    logic          pm_wakeup = 1'b0;
    logic          pm_lvolt = 1'b0;
    logic          pm_cpustall, clk_en, sleeping, lvolt_en;
    logic [NW:0]   wake_cause;
    logic [CW-1:0] sleep_count;

    int total = 0;
    int bad = 0;
    bit cmp_on = 1'b0;

    pm_sleep_controller #(.NUM_WAKE(NW), .CNT_WIDTH(CW), .DRAIN_CYCLES(DC)) dut (
        .clock(clock), .reset(reset), .interrupts(interrupts), .wake_mask(wake_mask),
        .settle_cycles(settle_cycles), .bus_idle(bus_idle), .pm_clksd(pm_clksd),
        .pm_cpu_gate(pm_cpu_gate), .pm_wakeup(pm_wakeup), .pm_lvolt(pm_lvolt),
        .pm_cpustall(pm_cpustall), .clk_en(clk_en), .sleeping(sleeping), .lvolt_en(lvolt_en),
        .wake_cause(wake_cause), .sleep_count(sleep_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase plus "cycles still owed" timers; outputs describe the phase of the previous cycle.
    typedef enum int {P_RUN, P_DRAIN, P_SLEEP, P_SETTLE} phase_e;
    phase_e   ph = P_RUN;
    int       owed = 0;
    int       tick = 0;
    int       clksd_prev = 0;
    bit       gate_prev = 0;
    bit       e_stall = 0, e_clk_en = 1, e_sleeping = 0, e_lvolt = 0;
    bit [NW:0] e_cause = '0;
    int       e_count = 0;

    always @(posedge clock or negedge reset) begin : model
        bit     wk, rise;
        phase_e nxt;
        if (!reset) begin
            ph = P_RUN; owed = 0; tick = 0; clksd_prev = 0; gate_prev = 0;
            e_stall = 0; e_clk_en = 1; e_sleeping = 0; e_lvolt = 0; e_cause = '0; e_count = 0;
        end else begin
            wk   = ((interrupts & wake_mask) != '0) || pm_wakeup;
            rise = pm_cpu_gate && !gate_prev;
            e_lvolt    = pm_lvolt && e_sleeping;
            e_stall    = (ph != P_RUN);
            e_sleeping = (ph == P_SLEEP);
            e_clk_en   = (ph == P_RUN) ? ((tick % (clksd_prev + 1)) == 0) : (ph != P_SLEEP);
            nxt = ph;
            case (ph)
                P_RUN: if (rise && !wk) begin nxt = P_DRAIN; owed = DC; e_count = 0; end
                P_DRAIN: begin
                    owed--;
                    if (wk) begin nxt = P_RUN; e_cause = {pm_wakeup, interrupts & wake_mask}; end
                    else if (owed <= 0 && bus_idle) nxt = P_SLEEP;
                end
                P_SLEEP: begin
                    if (e_count < (1 << CW) - 1) e_count++;
                    if (wk) begin
                        nxt = P_SETTLE; owed = int'(settle_cycles) + 1;
                        e_cause = {pm_wakeup, interrupts & wake_mask};
                    end
                end
                default: begin owed--; if (owed == 0) nxt = P_RUN; end
            endcase
            if (ph == P_RUN && nxt == P_RUN && int'(pm_clksd) == clksd_prev) tick++;
            else tick = 0;
            ph = nxt;
            gate_prev  = pm_cpu_gate;
            clksd_prev = int'(pm_clksd);
        end
    end

    always @(negedge clock) begin
        if (cmp_on) begin
            check("stall", 32'(pm_cpustall), 32'(e_stall));
            check("clk_en", 32'(clk_en), 32'(e_clk_en));
            check("sleeping", 32'(sleeping), 32'(e_sleeping));
            check("lvolt_en", 32'(lvolt_en), 32'(e_lvolt));
            check("wake_cause", 32'(wake_cause), 32'(e_cause));
            check("sleep_count", 32'(sleep_count), 32'(e_count));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_gate();
        pm_cpu_gate = 1'b1;
        cyc(1);
        pm_cpu_gate = 1'b0;
    endtask

    initial begin
        int hi;
        @(posedge clock);
        cmp_on = 1'b1;
        cyc(2);
        check("rst_stall", 32'(pm_cpustall), 32'd0);
        check("rst_clk_en", 32'(clk_en), 32'd1);
        check("rst_cause", 32'(wake_cause), 32'd0);
        reset = 1'b1;

        // Divider: period 4, then constant.
        pm_clksd = 4'd3;
        cyc(2);
        hi = 0;
        for (int i = 0; i < 8; i++) begin @(negedge clock); hi += int'(clk_en); end
        check("div3_pulses", 32'(hi), 32'd2);
        pm_clksd = 4'd0;
        cyc(3);
        hi = 0;
        for (int i = 0; i < 8; i++) begin @(negedge clock); hi += int'(clk_en); end
        check("div0_pulses", 32'(hi), 32'd8);
        cyc(1);

        // Full sleep cycle woken by line 7.
        wake_mask = 20'h00080;
        pulse_gate();
        check("stall_1cyc", 32'(pm_cpustall), 32'd0);
        cyc(1);
        check("stall_2cyc", 32'(pm_cpustall), 32'd1);
        cyc(3);
        cyc(100);
        interrupts = 20'h00080;
        cyc(1);
        check("cause_bit7", 32'(wake_cause), 32'h80);
        check("sleep_cnt_101", 32'(sleep_count), 32'd101);
        cyc(6);
        check("stall_hold_7", 32'(pm_cpustall), 32'd1);
        cyc(1);
        check("stall_low_8", 32'(pm_cpustall), 32'd0);
        interrupts = '0;
        cyc(2);

        // Masked line does not wake; pm_wakeup does.
        pulse_gate();
        cyc(10);
        interrupts = 20'h00008;
        cyc(10);
        check("masked_sleep", 32'(sleeping), 32'd1);
        pm_wakeup = 1'b1;
        cyc(1);
        check("cause_wakeup", 32'(wake_cause), 32'h100000);
        pm_wakeup = 1'b0;
        interrupts = '0;
        cyc(10);
        check("masked_run", 32'(pm_cpustall), 32'd0);

        // Bus hold keeps DRAIN.
        bus_idle = 1'b0;
        pulse_gate();
        cyc(21);
        check("hold_stall", 32'(pm_cpustall), 32'd1);
        check("hold_nosleep", 32'(sleeping), 32'd0);
        bus_idle = 1'b1;
        cyc(2);
        check("hold_release", 32'(sleeping), 32'd1);
        pm_wakeup = 1'b1;
        cyc(1);
        pm_wakeup = 1'b0;
        cyc(10);

        // Abort on the drain-expiry cycle, then re-arm only after gate toggles.
        pm_cpu_gate = 1'b1;
        cyc(4);
        interrupts = 20'h00080;
        cyc(1);
        check("abort_stall_hi", 32'(pm_cpustall), 32'd1);
        cyc(1);
        check("abort_stall_lo", 32'(pm_cpustall), 32'd0);
        check("abort_nosleep", 32'(sleeping), 32'd0);
        check("abort_count", 32'(sleep_count), 32'd0);
        check("abort_cause", 32'(wake_cause), 32'h80);
        interrupts = '0;
        cyc(10);
        check("no_rearm", 32'(pm_cpustall), 32'd0);
        pm_cpu_gate = 1'b0;
        cyc(1);
        pm_cpu_gate = 1'b1;
        cyc(3);
        check("rearm", 32'(pm_cpustall), 32'd1);

        // Reset while sleeping at low voltage.
        pm_lvolt = 1'b1;
        cyc(8);
        check("lvolt_on", 32'(lvolt_en), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_stall", 32'(pm_cpustall), 32'd0);
        check("arst_sleeping", 32'(sleeping), 32'd0);
        check("arst_lvolt", 32'(lvolt_en), 32'd0);
        check("arst_clk_en", 32'(clk_en), 32'd1);
        check("arst_count", 32'(sleep_count), 32'd0);
        pm_cpu_gate = 1'b0;
        pm_lvolt = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(3);
        check("post_rst_count", 32'(sleep_count), 32'd0);
        check("post_rst_stall", 32'(pm_cpustall), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
